// File: rtl/m_counter_sequencer_pkg.sv
// rtl/m_counter_sequencer_pkg.sv - opcodes, FSM encoding and command word layout for the counter sequencer
package counter_seq_pkg;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_DOWN  = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_UP    = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Command word is {op, data, len}; len sits at the bottom.
  localparam int OFF_LEN = 0;

  function automatic int cmd_w(input int cw);
    return 2 + 2 * cw;
  endfunction

  function automatic int off_data(input int cw);
    return cw;
  endfunction

  function automatic int off_op(input int cw);
    return 2 * cw;
  endfunction

  // Up/down commands run for a length; clear/load are single-cycle.
  function automatic logic is_count_op(input logic [1:0] op);
    return (op == OP_DOWN) || (op == OP_UP);
  endfunction

endpackage

// File: rtl/m_counter_sequencer_if.sv
// rtl/m_counter_sequencer_if.sv - command valid/ready bus between host and sequencer
interface m_counter_sequencer_if #(
  parameter int CW = 8
);
  logic          CMD_VALID;
  logic          CMD_READY;
  logic [1:0]    CMD_OP;
  logic [CW-1:0] CMD_DATA;
  logic [CW-1:0] CMD_LEN;

  modport master (
    output CMD_VALID,
    output CMD_OP,
    output CMD_DATA,
    output CMD_LEN,
    input  CMD_READY
  );

  modport slave (
    input  CMD_VALID,
    input  CMD_OP,
    input  CMD_DATA,
    input  CMD_LEN,
    output CMD_READY
  );
endinterface

// File: rtl/m_counter_sequencer_cmd_fifo.sv
// rtl/m_counter_sequencer_cmd_fifo.sv - synchronous command FIFO with flush, full and empty
module m_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  input  logic         flush,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         do_push;
  logic         do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointers: flush wins over push and pop, which may coincide
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  // Pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/m_counter_sequencer.sv
// rtl/m_counter_sequencer.sv - queued command sequencer for the 8-bit S-mode counter; SEQ_RCO_ABORT_EN ends up/down commands on RCO
module m_counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  m_counter_sequencer_if.slave        cmd,
  input  logic                        FLUSH,
  output logic [1:0]                  S_OUT,
  output logic [CW-1:0]               IN_OUT,
  output logic                        EN_OUT,
  input  logic                        RCO_IN,
  output logic                        BUSY,
  output logic                        DONE,
  output logic [CW-1:0]               RCO_CNT
);

  localparam int            WW         = cmd_w(CW);
  localparam logic [CW:0]   REMAIN_ONE = (CW+1)'(1);
  localparam logic [CW:0]   REMAIN_MAX = {1'b1, {CW{1'b0}}};
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  logic [WW-1:0] fifo_wdata;
  logic [WW-1:0] fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;

  logic [1:0]    head_op;
  logic [CW-1:0] head_data;
  logic [CW-1:0] head_len;

  state_e        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [CW:0]   remain_q, remain_d;
  logic [CW-1:0] rco_cnt_q, rco_cnt_d;
  logic [1:0]    s_q, s_d;
  logic [CW-1:0] in_q, in_d;
  logic          en_q, en_d;
  logic          done_q, done_d;
  logic          exec_last;

  assign fifo_wdata    = {cmd.CMD_OP, cmd.CMD_DATA, cmd.CMD_LEN};
  assign cmd.CMD_READY = !fifo_full;
  assign fifo_pop      = (state_q == ST_FETCH);

  assign head_op   = fifo_rdata[off_op(CW) +: 2];
  assign head_data = fifo_rdata[off_data(CW) +: CW];
  assign head_len  = fifo_rdata[OFF_LEN +: CW];

  m_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (WW)
  ) u_cmd_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (cmd.CMD_VALID),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .flush (FLUSH),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef SEQ_RCO_ABORT_EN
  assign exec_last = (remain_q == REMAIN_ONE) || (RCO_IN && is_count_op(op_q));
`else
  assign exec_last = (remain_q == REMAIN_ONE);
`endif

  // Next-state and next-output logic; outputs are computed one cycle ahead so they are registered
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    remain_d  = remain_q;
    rco_cnt_d = rco_cnt_q;
    s_d       = s_q;
    in_d      = in_q;
    en_d      = 1'b0;
    done_d    = 1'b0;
    if (FLUSH) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) state_d = ST_FETCH;
        end
        ST_FETCH: begin
          op_d      = head_op;
          rco_cnt_d = '0;
          if (!is_count_op(head_op))  remain_d = REMAIN_ONE;
          else if (head_len == '0)    remain_d = REMAIN_MAX;
          else                        remain_d = {1'b0, head_len};
          s_d       = head_op;
          in_d      = (head_op == OP_LOAD) ? head_data : '0;
          en_d      = 1'b1;
          state_d   = ST_EXEC;
        end
        ST_EXEC: begin
          if (RCO_IN && (rco_cnt_q != '1)) rco_cnt_d = rco_cnt_q + CNT_ONE;
          remain_d = remain_q - REMAIN_ONE;
          s_d      = op_q;
          if (exec_last) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            en_d = 1'b1;
          end
        end
        ST_DONE: begin
          state_d = fifo_empty ? ST_IDLE : ST_FETCH;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM state, working registers and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_CLEAR;
      remain_q  <= '0;
      rco_cnt_q <= '0;
      s_q       <= 2'b00;
      in_q      <= '0;
      en_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      remain_q  <= remain_d;
      rco_cnt_q <= rco_cnt_d;
      s_q       <= s_d;
      in_q      <= in_d;
      en_q      <= en_d;
      done_q    <= done_d;
    end
  end

  assign S_OUT   = s_q;
  assign IN_OUT  = in_q;
  assign EN_OUT  = en_q;
  assign DONE    = done_q;
  assign BUSY    = (state_q != ST_IDLE);
  assign RCO_CNT = rco_cnt_q;

endmodule

// File: tb/tb_m_counter_sequencer.sv
// tb/tb_m_counter_sequencer.sv - scoreboard bench for m_counter_sequencer with a behavioural 8-bit counter
module tb_m_counter_sequencer;
  import counter_seq_pkg::*;

  localparam int CW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          FLUSH = 1'b0;
  logic [1:0]    S_OUT;
  logic [CW-1:0] IN_OUT;
  logic          EN_OUT;
  logic          RCO_IN;
  logic          BUSY;
  logic          DONE;
  logic [CW-1:0] RCO_CNT;

  m_counter_sequencer_if #(.CW(CW)) cmd_if ();

  m_counter_sequencer #(.DEPTH(4), .CW(CW)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .cmd     (cmd_if),
    .FLUSH   (FLUSH),
    .S_OUT   (S_OUT),
    .IN_OUT  (IN_OUT),
    .EN_OUT  (EN_OUT),
    .RCO_IN  (RCO_IN),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .RCO_CNT (RCO_CNT)
  );

  always #5 CLK = ~CLK;

  // external counter: S=00 clear, 01 down, 10 load, 11 up; RCO at terminal count
  logic [7:0] ctr_q = 8'h00;
  always @(posedge CLK) begin
    if (EN_OUT) begin
      case (S_OUT)
        2'b00: ctr_q <= 8'h00;
        2'b01: ctr_q <= ctr_q - 8'h01;
        2'b10: ctr_q <= IN_OUT;
        default: ctr_q <= ctr_q + 8'h01;
      endcase
    end
  end
  assign RCO_IN = EN_OUT && (((S_OUT == OP_UP) && (ctr_q == 8'hFF)) ||
                             ((S_OUT == OP_DOWN) && (ctr_q == 8'h00)));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [1:0] s;
    logic [7:0] d;
    int         n;
    logic [7:0] rco;
  } rec_t;

  rec_t sb_q[$];
  rec_t cur;
  bit   cur_valid = 1'b0;
  int   en_cnt    = 0;
  int   drop_seq  = 0;
  int   drop_seen = 0;

  // monitor: each command's EN cycles and its DONE are checked against the scoreboard
  always @(negedge CLK) begin
    if (drop_seq != drop_seen) begin
      sb_q.delete();
      cur_valid = 1'b0;
      drop_seen = drop_seq;
    end
    if (!RST) begin
      if (EN_OUT && !cur_valid) begin
        if (sb_q.size() > 0) begin
          cur       = sb_q.pop_front();
          cur_valid = 1'b1;
          en_cnt    = 0;
        end else begin
          chk("en_unexpected", EN_OUT, 0);
        end
      end
      if (EN_OUT && cur_valid) begin
        chk("s_out", S_OUT, cur.s);
        chk("in_out", IN_OUT, cur.d);
        en_cnt++;
      end
      if (DONE) begin
        if (cur_valid) begin
          chk("en_len", en_cnt, cur.n);
          chk("rco_cnt", RCO_CNT, cur.rco);
          chk("done_en_low", EN_OUT, 0);
          cur_valid = 1'b0;
        end else begin
          chk("done_unexpected", DONE, 0);
        end
      end
    end
  end

  task automatic push(input logic [1:0] op, input logic [7:0] data, input logic [7:0] len,
                      input int n, input logic [7:0] rco, output int waited);
    rec_t r;
    waited = 0;
    cmd_if.CMD_VALID = 1'b1;
    cmd_if.CMD_OP    = op;
    cmd_if.CMD_DATA  = data;
    cmd_if.CMD_LEN   = len;
    while (!cmd_if.CMD_READY && waited < 1000) begin
      @(posedge CLK); #1;
      waited++;
    end
    chk("push_ready", cmd_if.CMD_READY, 1);
    r.s   = op;
    r.d   = (op == OP_LOAD) ? data : 8'h00;
    r.n   = n;
    r.rco = rco;
    sb_q.push_back(r);
    @(posedge CLK); #1;
    cmd_if.CMD_VALID = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int g;
    g = 0;
    repeat (3) @(posedge CLK);
    #1;
    while (BUSY && g < 2000) begin
      @(posedge CLK); #1;
      g++;
    end
    chk(tag, BUSY, 0);
    @(negedge CLK);
    chk({tag, "_sb"}, sb_q.size() + int'(cur_valid), 0);
    @(posedge CLK); #1;
  endtask

  initial begin
    int w;
    int g;
    cmd_if.CMD_VALID = 1'b0;
    cmd_if.CMD_OP    = 2'b00;
    cmd_if.CMD_DATA  = 8'h00;
    cmd_if.CMD_LEN   = 8'h00;

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_en", EN_OUT, 0);
    chk("rst_s", S_OUT, 0);
    chk("rst_in", IN_OUT, 0);
    chk("rst_done", DONE, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_rco", RCO_CNT, 0);
    RST = 1'b0;
    #1;
    chk("rst_ready", cmd_if.CMD_READY, 1);
    @(posedge CLK); #1;

    // single up/5: latency and exact length
    push(OP_UP, 8'h00, 8'd5, 5, 8'd0, w);
    chk("t1_busy_k", BUSY, 0);
    chk("t1_en_k", EN_OUT, 0);
    @(posedge CLK); #1;
    chk("t1_busy_fetch", BUSY, 1);
    chk("t1_en_fetch", EN_OUT, 0);
    @(posedge CLK); #1;
    chk("t1_en_exec", EN_OUT, 1);
    chk("t1_s_exec", S_OUT, 2'b11);
    g = 0;
    while (!DONE && g < 20) begin
      @(posedge CLK); #1;
      g++;
    end
    chk("t1_done", DONE, 1);
    @(posedge CLK); #1;
    chk("t1_done_pulse", DONE, 0);
    chk("t1_busy_after", BUSY, 0);
    chk("t1_ctr", ctr_q, 8'h05);

    // load 96 then up 3 back to back
    push(OP_LOAD, 8'h96, 8'h00, 1, 8'd0, w);
    push(OP_UP, 8'h00, 8'd3, 3, 8'd0, w);
    wait_idle("t2_idle");
    chk("t2_ctr", ctr_q, 8'h99);

    // fill the FIFO behind a 256-cycle command
    push(OP_CLEAR, 8'h00, 8'h00, 1, 8'd0, w);
    push(OP_UP, 8'h00, 8'h00, 256, 8'd1, w);
    repeat (10) @(posedge CLK);
    #1;
    chk("t3_in_exec", EN_OUT, 1);
    push(OP_UP, 8'h00, 8'd2, 2, 8'd0, w);
    push(OP_DOWN, 8'h00, 8'd1, 1, 8'd0, w);
    push(OP_CLEAR, 8'h00, 8'h00, 1, 8'd0, w);
    push(OP_LOAD, 8'hA5, 8'h00, 1, 8'd0, w);
    chk("t3_ready_full", cmd_if.CMD_READY, 0);
    chk("t3_still_exec", EN_OUT, 1);
    push(OP_UP, 8'h00, 8'd1, 1, 8'd0, w);
    chk("t3_fifth_held", (w > 200), 1);
    wait_idle("t3_idle");
    chk("t3_ctr", ctr_q, 8'hA6);

    // clear then down/2 through zero
    push(OP_CLEAR, 8'h00, 8'h00, 1, 8'd0, w);
`ifdef SEQ_RCO_ABORT_EN
    push(OP_DOWN, 8'h00, 8'd2, 1, 8'd1, w);
    wait_idle("t4_idle");
    chk("t4_ctr", ctr_q, 8'hFF);
`else
    push(OP_DOWN, 8'h00, 8'd2, 2, 8'd1, w);
    wait_idle("t4_idle");
    chk("t4_ctr", ctr_q, 8'hFE);
`endif

    // flush mid-EXEC with two queued and a simultaneous push
    push(OP_CLEAR, 8'h00, 8'h00, 1, 8'd0, w);
    push(OP_UP, 8'h00, 8'd50, 50, 8'd0, w);
    push(OP_UP, 8'h00, 8'd3, 3, 8'd0, w);
    push(OP_LOAD, 8'h11, 8'h00, 1, 8'd0, w);
    repeat (8) @(posedge CLK);
    #1;
    chk("t5_pre_en", EN_OUT, 1);
    FLUSH            = 1'b1;
    cmd_if.CMD_VALID = 1'b1;
    cmd_if.CMD_OP    = OP_LOAD;
    cmd_if.CMD_DATA  = 8'h77;
    @(posedge CLK); #1;
    FLUSH            = 1'b0;
    cmd_if.CMD_VALID = 1'b0;
    drop_seq++;
    chk("t5_en", EN_OUT, 0);
    chk("t5_busy", BUSY, 0);
    chk("t5_done", DONE, 0);
    chk("t5_ready", cmd_if.CMD_READY, 1);
    repeat (10) @(posedge CLK);
    #1;
    chk("t5_busy_later", BUSY, 0);

    // asynchronous reset mid-EXEC
    push(OP_CLEAR, 8'h00, 8'h00, 1, 8'd0, w);
    push(OP_UP, 8'h00, 8'd20, 20, 8'd0, w);
    push(OP_UP, 8'h00, 8'd2, 2, 8'd0, w);
    repeat (8) @(posedge CLK);
    #3;
    chk("t6_pre_s", S_OUT, 2'b11);
    chk("t6_pre_en", EN_OUT, 1);
    RST = 1'b1;
    drop_seq++;
    #1;
    chk("t6_en", EN_OUT, 0);
    chk("t6_s", S_OUT, 0);
    chk("t6_in", IN_OUT, 0);
    chk("t6_done", DONE, 0);
    chk("t6_busy", BUSY, 0);
    chk("t6_rco", RCO_CNT, 0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    chk("t6_ready", cmd_if.CMD_READY, 1);
    repeat (10) @(posedge CLK);
    #1;
    chk("t6_busy_later", BUSY, 0);
    chk("t6_en_later", EN_OUT, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
